// File: rtl/rx_frame_buffer_ctrl.sv
// rx_frame_buffer_ctrl
//
// Writes received frames into a circular packet RAM, then either commits the
// frame and publishes a one-entry descriptor, or rolls the write pointer back
// to the last committed position. Also drives a near-full flag back to the
// receiver and counts committed and dropped frames.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   data_in, data_in_enable      byte stream from the receiver
//   data_in_start, data_in_end   frame delimiters (start qualified by enable)
//   error                        frame bad, qualified by data_in_end
//   fifo_full                    fewer than FULL_MARGIN free bytes (combinational)
//   ram_wr_en/addr/data          registered RAM write port
//   rd_ptr                       consumer free pointer, wrap bit in MSB
//   frame_valid/addr/length      descriptor, held until frame_ack
//   frame_ack                    consumer takes the descriptor
//   frames_ok, frames_dropped    wrapping frame counters
//
// state    | meaning
// IDLE     | between frames, waiting for start
// WRITE    | frame in progress, bytes going to RAM
// OVERFLOW | buffer filled mid-frame, discarding until end
module rx_frame_buffer_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int FULL_MARGIN = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            data_in,
    input  logic                  data_in_enable,
    input  logic                  data_in_start,
    input  logic                  data_in_end,
    input  logic                  error,
    output logic                  fifo_full,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [7:0]            ram_wr_data,
    input  logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  frame_valid,
    output logic [ADDR_WIDTH-1:0] frame_addr,
    output logic [15:0]           frame_length,
    input  logic                  frame_ack,
    output logic [15:0]           frames_ok,
    output logic [15:0]           frames_dropped
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] FULL_THRESH = DEPTH_P - PW'(FULL_MARGIN);

    typedef enum logic [1:0] {IDLE, WRITE, OVERFLOW} state_t;

    state_t                state;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         commit_ptr;
    logic [ADDR_WIDTH-1:0] frame_start;
    logic [15:0]           len;

    logic [PW-1:0] used;
    logic [PW-1:0] wr_base;
    logic [PW-1:0] base_used;
    logic [PW-1:0] wr_ptr_after;
    logic [15:0]   len_after;
    logic          restart;
    logic          abort;
    logic          byte_valid;
    logic          room;
    logic          do_write;
    logic          in_frame;
    logic          overflowed;
    logic          resolve;
    logic          slot_free;
    logic          commit;
    logic          rollback;
    logic [1:0]    drop_inc;

    // A start in WRITE abandons the current frame, so the incoming byte is
    // placed relative to commit_ptr rather than wr_ptr. Room is checked at that
    // base so the block never writes past rd_ptr + DEPTH. A byte that comes
    // with end is written first; the frame is then resolved on the same edge.
    always_comb begin
        used         = wr_ptr - rd_ptr;
        fifo_full    = used > FULL_THRESH;
        restart      = data_in_enable && data_in_start && (state != OVERFLOW);
        abort        = restart && (state == WRITE);
        byte_valid   = data_in_enable && ((state == WRITE) || restart);
        wr_base      = restart ? commit_ptr : wr_ptr;
        base_used    = wr_base - rd_ptr;
        room         = base_used < DEPTH_P;
        do_write     = byte_valid && room;
        wr_ptr_after = wr_base + PW'(do_write);
        len_after    = (restart ? 16'd0 : len) + 16'(do_write);
        in_frame     = (state == WRITE) || restart;
        overflowed   = (state == OVERFLOW) || (byte_valid && !room);
        resolve      = data_in_end && (in_frame || (state == OVERFLOW));
        slot_free    = !frame_valid || frame_ack;
        commit       = resolve && !overflowed && !error && slot_free;
        rollback     = resolve && !commit;
        drop_inc     = 2'(abort) + 2'(rollback);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            frame_start    <= '0;
            len            <= '0;
            ram_wr_en      <= 1'b0;
            ram_wr_addr    <= '0;
            ram_wr_data    <= '0;
            frame_valid    <= 1'b0;
            frame_addr     <= '0;
            frame_length   <= '0;
            frames_ok      <= '0;
            frames_dropped <= '0;
        end else begin
            ram_wr_en <= do_write;
            if (do_write) begin
                ram_wr_addr <= wr_base[ADDR_WIDTH-1:0];
                ram_wr_data <= data_in;
            end

            if (restart) begin
                frame_start <= commit_ptr[ADDR_WIDTH-1:0];
            end
            len            <= len_after;
            frames_dropped <= frames_dropped + 16'(drop_inc);

            if (rollback) begin
                wr_ptr <= commit_ptr;
            end else begin
                wr_ptr <= wr_ptr_after;
            end

            // A commit on the ack cycle replaces the descriptor in place.
            if (commit) begin
                commit_ptr   <= wr_ptr_after;
                frame_valid  <= 1'b1;
                frame_addr   <= restart ? commit_ptr[ADDR_WIDTH-1:0] : frame_start;
                frame_length <= len_after;
                frames_ok    <= frames_ok + 16'd1;
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end

            if (resolve) begin
                state <= IDLE;
            end else if (overflowed) begin
                state <= OVERFLOW;
            end else if (in_frame) begin
                state <= WRITE;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// tb_rx_frame_buffer_ctrl
//
// Directed bench for rx_frame_buffer_ctrl with a 64-byte buffer. A frame-level
// model tracks pointers, descriptor and counters as plain integers and is
// compared against the DUT on every falling edge; literal checks after each
// scenario pin the expected addresses, lengths and counts.
module tb_rx_frame_buffer_ctrl;
    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int PM     = 128;
    localparam int MARGIN = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    data_in = '0;
    logic          data_in_enable = 1'b0;
    logic          data_in_start = 1'b0;
    logic          data_in_end = 1'b0;
    logic          error = 1'b0;
    logic          fifo_full;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [7:0]    ram_wr_data;
    logic [AW:0]   rd_ptr = '0;
    logic          frame_valid;
    logic [AW-1:0] frame_addr;
    logic [15:0]   frame_length;
    logic          frame_ack = 1'b0;
    logic [15:0]   frames_ok;
    logic [15:0]   frames_dropped;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    rx_frame_buffer_ctrl #(.ADDR_WIDTH(AW), .FULL_MARGIN(MARGIN)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_enable (data_in_enable),
        .data_in_start  (data_in_start),
        .data_in_end    (data_in_end),
        .error          (error),
        .fifo_full      (fifo_full),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .rd_ptr         (rd_ptr),
        .frame_valid    (frame_valid),
        .frame_addr     (frame_addr),
        .frame_length   (frame_length),
        .frame_ack      (frame_ack),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int m_wr, m_commit, m_start, m_len;
    bit m_active, m_ovf;
    bit m_fv;
    int m_faddr, m_flen;
    logic [15:0] m_ok, m_drop;
    bit m_we;
    int m_waddr, m_wdata;
    bit m_ack_taken, m_slot_free;

    function automatic int m_used(input int wr, input int rd);
        return (wr - rd + PM) % PM;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_wr = 0; m_commit = 0; m_start = 0; m_len = 0;
            m_active = 0; m_ovf = 0; m_fv = 0; m_faddr = 0; m_flen = 0;
            m_ok = '0; m_drop = '0; m_we = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            m_we        = 0;
            m_ack_taken = m_fv && frame_ack;
            m_slot_free = !m_fv || frame_ack;
            if (m_ack_taken) m_fv = 0;
            if (data_in_enable && data_in_start && !m_ovf) begin
                if (m_active) begin
                    m_drop++;
                    m_wr = m_commit;
                end
                m_active = 1;
                m_len    = 0;
                m_start  = m_commit;
            end
            if (data_in_enable && m_active && !m_ovf) begin
                if (m_used(m_wr, int'(rd_ptr)) == DEPTH) begin
                    m_ovf = 1;
                end else begin
                    m_we    = 1;
                    m_waddr = m_wr % DEPTH;
                    m_wdata = int'(data_in);
                    m_wr    = (m_wr + 1) % PM;
                    m_len++;
                end
            end
            if (data_in_end && m_active) begin
                if (!m_ovf && !error && m_slot_free) begin
                    m_commit = m_wr;
                    m_fv     = 1;
                    m_faddr  = m_start % DEPTH;
                    m_flen   = m_len;
                    m_ok++;
                end else begin
                    m_wr = m_commit;
                    m_drop++;
                end
                m_active = 0;
                m_ovf    = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("fifo_full", int'(fifo_full),
                int'(m_used(m_wr, int'(rd_ptr)) > DEPTH - MARGIN));
            chk("ram_wr_en", int'(ram_wr_en), int'(m_we));
            if (m_we) begin
                chk("ram_wr_addr", int'(ram_wr_addr), m_waddr);
                chk("ram_wr_data", int'(ram_wr_data), m_wdata);
            end
            chk("frame_valid", int'(frame_valid), int'(m_fv));
            if (m_fv) begin
                chk("frame_addr", int'(frame_addr), m_faddr);
                chk("frame_length", int'(frame_length), m_flen);
            end
            chk("frames_ok", int'(frames_ok), int'(m_ok));
            chk("frames_dropped", int'(frames_dropped), int'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] d, input logic en, input logic st,
                       input logic fin, input logic err, input logic ack);
        data_in        = d;
        data_in_enable = en;
        data_in_start  = st;
        data_in_end    = fin;
        error          = err;
        frame_ack      = ack;
        @(posedge clock);
        #1;
        data_in_enable = 1'b0;
        data_in_start  = 1'b0;
        data_in_end    = 1'b0;
        error          = 1'b0;
        frame_ack      = 1'b0;
    endtask

    task automatic send_frame(input int n, input int base, input logic err,
                              input logic ack_end, input logic with_end);
        for (int i = 0; i < n; i++) begin
            put(8'(base + i), 1'b1, i == 0, with_end && (i == n - 1),
                err && (i == n - 1), ack_end && (i == n - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) put(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        rd_ptr = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ram_wr_en", int'(ram_wr_en), 0);
        chk("rst_frame_valid", int'(frame_valid), 0);
        chk("rst_frames_ok", int'(frames_ok), 0);
        chk("rst_fifo_full", int'(fifo_full), 0);
        reset = 1'b0;

        // 64-byte good frame fills the whole buffer
        send_frame(64, 0, 1'b0, 1'b0, 1'b1);
        chk("t1_last_wr_en", int'(ram_wr_en), 1);
        chk("t1_last_wr_addr", int'(ram_wr_addr), 63);
        chk("t1_last_wr_data", int'(ram_wr_data), 63);
        chk("t1_valid", int'(frame_valid), 1);
        chk("t1_addr", int'(frame_addr), 0);
        chk("t1_length", int'(frame_length), 64);
        chk("t1_ok", int'(frames_ok), 1);
        chk("t1_full", int'(fifo_full), 1);

        // errored frame rolls back, next frame reuses address 0
        apply_reset();
        send_frame(64, 8'h80, 1'b1, 1'b0, 1'b1);
        chk("t2_valid", int'(frame_valid), 0);
        chk("t2_dropped", int'(frames_dropped), 1);
        idle(1);
        send_frame(5, 8'h10, 1'b0, 1'b0, 1'b1);
        chk("t2_next_addr", int'(frame_addr), 0);
        chk("t2_next_length", int'(frame_length), 5);
        chk("t2_next_ok", int'(frames_ok), 1);

        // near-full flag and overflow after a 40-byte frame
        apply_reset();
        send_frame(40, 0, 1'b0, 1'b0, 1'b1);
        chk("t3_full_40", int'(fifo_full), 0);
        for (int i = 0; i < 30; i++) begin
            put(8'(i + 100), 1'b1, i == 0, i == 29, 1'b0, 1'b0);
            if (i == 15) chk("t3_full_used56", int'(fifo_full), 0);
            if (i == 16) chk("t3_full_used57", int'(fifo_full), 1);
        end
        chk("t3_dropped", int'(frames_dropped), 1);
        chk("t3_full_after", int'(fifo_full), 0);
        chk("t3_desc_kept", int'(frame_length), 40);
        put(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ack_clears", int'(frame_valid), 0);
        send_frame(4, 8'h55, 1'b0, 1'b0, 1'b1);
        chk("t3_next_addr", int'(frame_addr), 40);
        chk("t3_next_length", int'(frame_length), 4);

        // two frames, descriptor slot occupied
        apply_reset();
        send_frame(3, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(4, 8'h11, 1'b0, 1'b0, 1'b1);
        chk("t4_dropped", int'(frames_dropped), 1);
        chk("t4_ok", int'(frames_ok), 1);
        chk("t4_length", int'(frame_length), 3);
        apply_reset();
        send_frame(3, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(4, 8'h11, 1'b0, 1'b1, 1'b1);
        chk("t4b_valid", int'(frame_valid), 1);
        chk("t4b_addr", int'(frame_addr), 3);
        chk("t4b_length", int'(frame_length), 4);
        chk("t4b_ok", int'(frames_ok), 2);
        chk("t4b_dropped", int'(frames_dropped), 0);
        idle(1);
        chk("t4b_valid_held", int'(frame_valid), 1);

        // start mid-frame restarts at the commit point
        apply_reset();
        send_frame(20, 0, 1'b0, 1'b0, 1'b0);
        send_frame(5, 8'h40, 1'b0, 1'b0, 1'b1);
        chk("t5_dropped", int'(frames_dropped), 1);
        chk("t5_addr", int'(frame_addr), 0);
        chk("t5_length", int'(frame_length), 5);

        // wrap around the end of the buffer
        apply_reset();
        send_frame(60, 0, 1'b0, 1'b0, 1'b1);
        put(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rd_ptr = 7'd60;
        for (int i = 0; i < 10; i++) begin
            put(8'(i + 200), 1'b1, i == 0, i == 9, 1'b0, 1'b0);
            if (i == 3) chk("t5w_addr63", int'(ram_wr_addr), 63);
            if (i == 4) chk("t5w_addr0", int'(ram_wr_addr), 0);
        end
        chk("t5w_frame_addr", int'(frame_addr), 60);
        chk("t5w_length", int'(frame_length), 10);
        chk("t5w_ok", int'(frames_ok), 2);

        // reset in the middle of a frame
        apply_reset();
        send_frame(4, 8'h30, 1'b0, 1'b0, 1'b1);
        send_frame(10, 8'h20, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_wr_en", int'(ram_wr_en), 0);
        chk("t6_wr_addr", int'(ram_wr_addr), 0);
        chk("t6_wr_data", int'(ram_wr_data), 0);
        chk("t6_valid", int'(frame_valid), 0);
        chk("t6_length", int'(frame_length), 0);
        chk("t6_ok", int'(frames_ok), 0);
        chk("t6_dropped", int'(frames_dropped), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_frame(3, 8'h70, 1'b0, 1'b0, 1'b1);
        chk("t6_next_addr", int'(frame_addr), 0);
        chk("t6_next_ok", int'(frames_ok), 1);
        chk("t6_next_dropped", int'(frames_dropped), 0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
